// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the serial sequence link (pattern
// generator and detectors).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

  // Transmitter FSM state encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } seq_state_e;

  // Widths shared between the generator and the detectors
  localparam int SEQ_PAT_W = 4;
  localparam int SEQ_REP_W = 8;
  localparam int SEQ_GAP_W = 4;

  // Default pattern, transmitted MSB-first
  localparam logic [SEQ_PAT_W-1:0] SEQ_PAT_1011 = 4'b1011;

endpackage

`default_nettype wire

// File: rtl/seq_piso.sv
// ---------------------------------------------------------------------------
// seq_piso
// PAT_W-bit parallel-in serial-out shifter. The register MSB is the bit
// being transmitted in the current cycle; msb_next is the bit that will sit
// in the MSB after this edge, so the caller can register it directly.
// last flags that the current bit is the final one of the word.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_piso #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] load_data,
  output logic             msb_next,
  output logic             last
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  logic [PAT_W-1:0] shreg;
  logic [IDX_W-1:0] idx;

  // Load a fresh word or shift one bit out; index counts PAT_W-1 down to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= load_data;
      idx   <= IDX_W'(PAT_W - 1);
    end else if (shift) begin
      shreg <= {shreg[PAT_W-2:0], 1'b0};
      idx   <= idx - IDX_W'(1);
    end
  end

  // Look-ahead of the MSB and terminal-bit flag
  always_comb begin
    if (load) begin
      msb_next = load_data[PAT_W-1];
    end else if (shift) begin
      msb_next = shreg[PAT_W-2];
    end else begin
      msb_next = shreg[PAT_W-1];
    end
    last = (idx == '0);
  end

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// seq_pattern_gen
// Serial pattern transmitter: on start, shifts PATTERN MSB-first onto a
// 1-bit line rep_cnt times with an optional idle gap between repetitions.
// All outputs are registered. Optional build macro SEQ_GEN_ERR_INJECT_EN adds
// inj_err, which inverts the last bit of the first repetition.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_PAT_1011,
  parameter int               REP_W   = SEQ_REP_W,
  parameter int               GAP_W   = SEQ_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
`ifdef SEQ_GEN_ERR_INJECT_EN
  input  logic             inj_err,
`endif
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  seq_state_e       state;
  seq_state_e       next_state;
  logic [REP_W-1:0] reps;
  logic [GAP_W-1:0] gap_reload;
  logic [GAP_W-1:0] gap_cnt;

  logic             capture;
  logic             load;
  logic             shift;
  logic             rep_dec;
  logic             gap_load;
  logic             gap_dec;
  logic             done_evt;

  logic [PAT_W-1:0] load_data;
  logic             bit_next;
  logic             last_bit;

  logic             out_d;
  logic             valid_d;
  logic             busy_d;
  logic             done_d;

  // The first repetition is always loaded from IDLE, so the corrupted word
  // only ever reaches the line once per transmission.
`ifdef SEQ_GEN_ERR_INJECT_EN
  assign load_data = ((state == IDLE) && inj_err) ? (PATTERN ^ PAT_W'(1)) : PATTERN;
`else
  assign load_data = PATTERN;
`endif

  seq_piso #(
    .PAT_W(PAT_W)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .load_data(load_data),
    .msb_next (bit_next),
    .last     (last_bit)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath strobes; abort always wins over start
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    rep_dec    = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    done_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (rep_cnt != '0) begin
            capture    = 1'b1;
            load       = 1'b1;
            next_state = SEND;
          end else begin
            done_evt = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          next_state = IDLE;
        end else if (last_bit) begin
          rep_dec = 1'b1;
          if (reps > REP_W'(1)) begin
            if (gap_reload != '0) begin
              gap_load   = 1'b1;
              next_state = GAP;
            end else begin
              load = 1'b1;
            end
          end else begin
            done_evt   = 1'b1;
            next_state = IDLE;
          end
        end else begin
          shift = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          next_state = IDLE;
        end else if (gap_cnt == GAP_W'(1)) begin
          load       = 1'b1;
          next_state = SEND;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode of the upcoming cycle, registered below
  always_comb begin
    valid_d = (next_state == SEND);
    out_d   = valid_d & bit_next;
    busy_d  = (next_state != IDLE);
    done_d  = done_evt;
  end

  // Repetition and gap counters, captured only when a start is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reps       <= '0;
      gap_reload <= '0;
      gap_cnt    <= '0;
    end else begin
      if (capture) begin
        reps       <= rep_cnt;
        gap_reload <= gap;
      end else if (rep_dec) begin
        reps <= reps - REP_W'(1);
      end
      if (gap_load) begin
        gap_cnt <= gap_reload;
      end else if (gap_dec) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out       <= out_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_gen
// Directed self-checking bench for seq_pattern_gen.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rep_cnt = '0;
  logic [3:0] gap = '0;
  logic       abort = 1'b0;
`ifdef SEQ_GEN_ERR_INJECT_EN
  logic       inj_err = 1'b0;
`endif
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Captured traces, first observed cycle in the most significant used bit
  logic [31:0] cv, co, cb, cd;

  seq_pattern_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rep_cnt  (rep_cnt),
    .gap      (gap),
    .abort    (abort),
`ifdef SEQ_GEN_ERR_INJECT_EN
    .inj_err  (inj_err),
`endif
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Drive start/abort per cycle (bit c = cycle c) and record cycles 1..n
  task automatic run(input int n, input logic [31:0] st, input logic [31:0] ab);
    cv = '0; co = '0; cb = '0; cd = '0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c > 0) begin
        cv = {cv[30:0], out_valid};
        co = {co[30:0], out};
        cb = {cb[30:0], busy};
        cd = {cd[30:0], done};
      end
      start = st[c];
      abort = ab[c];
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset out: got %b exp 0", out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b exp 0", done); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] e;
    rep_cnt = 8'd1; gap = 4'd0;
    run(7, 32'h1, 32'h0);
    e = 7'b1111000; checks++; if (cv !== e) begin errors++; $display("FAIL single valid: got %b exp %b", cv, e); end
    e = 7'b1011000; checks++; if (co !== e) begin errors++; $display("FAIL single out: got %b exp %b", co, e); end
    e = 7'b1111000; checks++; if (cb !== e) begin errors++; $display("FAIL single busy: got %b exp %b", cb, e); end
    e = 7'b0000100; checks++; if (cd !== e) begin errors++; $display("FAIL single done: got %b exp %b", cd, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    rep_cnt = 8'd3; gap = 4'd0;
    run(14, 32'h1, 32'h0);
    e = 14'b11111111111100; checks++; if (cv !== e) begin errors++; $display("FAIL b2b valid: got %b exp %b", cv, e); end
    e = 14'b10111011101100; checks++; if (co !== e) begin errors++; $display("FAIL b2b out: got %b exp %b", co, e); end
    e = 14'b11111111111100; checks++; if (cb !== e) begin errors++; $display("FAIL b2b busy: got %b exp %b", cb, e); end
    e = 14'b00000000000010; checks++; if (cd !== e) begin errors++; $display("FAIL b2b done: got %b exp %b", cd, e); end
  endtask

  task automatic test_gap();
    logic [31:0] e;
    rep_cnt = 8'd2; gap = 4'd2;
    run(12, 32'h1, 32'h0);
    e = 12'b111100111100; checks++; if (cv !== e) begin errors++; $display("FAIL gap valid: got %b exp %b", cv, e); end
    e = 12'b101100101100; checks++; if (co !== e) begin errors++; $display("FAIL gap out: got %b exp %b", co, e); end
    e = 12'b111111111100; checks++; if (cb !== e) begin errors++; $display("FAIL gap busy: got %b exp %b", cb, e); end
    e = 12'b000000000010; checks++; if (cd !== e) begin errors++; $display("FAIL gap done: got %b exp %b", cd, e); end
  endtask

  task automatic test_abort();
    logic [31:0] e;
    rep_cnt = 8'd2; gap = 4'd0;
    // start at cycle 0, abort at cycle 2, restart at cycle 3
    run(12, 32'h9, 32'h4);
    e = 12'b110111111110; checks++; if (cv !== e) begin errors++; $display("FAIL abort valid: got %b exp %b", cv, e); end
    e = 12'b100101110110; checks++; if (co !== e) begin errors++; $display("FAIL abort out: got %b exp %b", co, e); end
    e = 12'b110111111110; checks++; if (cb !== e) begin errors++; $display("FAIL abort busy: got %b exp %b", cb, e); end
    e = 12'b000000000001; checks++; if (cd !== e) begin errors++; $display("FAIL abort done: got %b exp %b", cd, e); end
  endtask

  task automatic test_zero_reps();
    logic [31:0] e;
    rep_cnt = 8'd0; gap = 4'd0;
    run(3, 32'h1, 32'h0);
    e = 3'b000; checks++; if (cv !== e) begin errors++; $display("FAIL zero valid: got %b exp %b", cv, e); end
    e = 3'b000; checks++; if (cb !== e) begin errors++; $display("FAIL zero busy: got %b exp %b", cb, e); end
    e = 3'b100; checks++; if (cd !== e) begin errors++; $display("FAIL zero done: got %b exp %b", cd, e); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] e;
    rep_cnt = 8'd1; gap = 4'd0;
    fork
      run(7, 32'h5, 32'h0);
      begin
        repeat (3) @(negedge clk);
        #1 rep_cnt = 8'd3; gap = 4'd5;
      end
    join
    e = 7'b1111000; checks++; if (cv !== e) begin errors++; $display("FAIL busy_start valid: got %b exp %b", cv, e); end
    e = 7'b1011000; checks++; if (co !== e) begin errors++; $display("FAIL busy_start out: got %b exp %b", co, e); end
    e = 7'b0000100; checks++; if (cd !== e) begin errors++; $display("FAIL busy_start done: got %b exp %b", cd, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    rep_cnt = 8'd3; gap = 4'd0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid pre valid: got %b exp 1", out_valid); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out, out_valid, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL rstmid async: got %b exp 0000", {out, out_valid, busy, done});
    end
    @(negedge clk); rst = 1'b1;
    run(6, 32'h0, 32'h0);
    e = 6'b000000; checks++; if (cv !== e) begin errors++; $display("FAIL rstmid idle valid: got %b exp %b", cv, e); end
    e = 6'b000000; checks++; if (cb !== e) begin errors++; $display("FAIL rstmid idle busy: got %b exp %b", cb, e); end
    e = 6'b000000; checks++; if (cd !== e) begin errors++; $display("FAIL rstmid idle done: got %b exp %b", cd, e); end
    rep_cnt = 8'd1;
    run(6, 32'h1, 32'h0);
    e = 6'b111100; checks++; if (cv !== e) begin errors++; $display("FAIL rstmid restart valid: got %b exp %b", cv, e); end
    e = 6'b000010; checks++; if (cd !== e) begin errors++; $display("FAIL rstmid restart done: got %b exp %b", cd, e); end
  endtask

`ifdef SEQ_GEN_ERR_INJECT_EN
  task automatic test_inject();
    logic [31:0] e;
    rep_cnt = 8'd2; gap = 4'd0; inj_err = 1'b1;
    run(9, 32'h1, 32'h0);
    inj_err = 1'b0;
    e = 9'b101010110; checks++; if (co !== e) begin errors++; $display("FAIL inject out: got %b exp %b", co, e); end
    e = 9'b111111110; checks++; if (cv !== e) begin errors++; $display("FAIL inject valid: got %b exp %b", cv, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_abort();
    test_zero_reps();
    test_start_while_busy();
    test_reset_mid();
`ifdef SEQ_GEN_ERR_INJECT_EN
    test_inject();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial pattern transmitter: the transmit end of the serial sequence-detection link.
- On a start request it shifts a fixed PAT_W-bit pattern MSB-first onto a 1-bit line.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Drives the serial input of the Mealy sequence detectors and their benches; default pattern is 1011.

Parameters:
- PAT_W, 4, pattern length in bits (2..16).
- PATTERN, 4'b1011, pattern transmitted MSB-first.
- REP_W, 8, width of the repetition count.
- GAP_W, 4, width of the inter-repetition gap count.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- start  input  1  one-cycle request; sampled only in IDLE.
- rep_cnt  input  REP_W  number of pattern repetitions; captured with start.
- gap  input  GAP_W  idle cycles between repetitions; captured with start.
- abort  input  1  terminate the current transmission.
- out  output  1  serial data bit, registered.
- out_valid  output  1  out carries a pattern bit this cycle.
- busy  output  1  high in SEND or GAP.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, out=0, out_valid=0, busy=0, done=0. Captured counts are cleared.
- All outputs are registered (Moore). Latency is start at edge N → first bit on out at cycle N+1.
- States:
  - IDLE: on start with rep_cnt>0, load the shifter with PATTERN, rep counter=rep_cnt, gap reload=gap, go to SEND. On start with rep_cnt==0, stay in IDLE and pulse done next cycle. Otherwise hold.
  - SEND: out=current MSB, out_valid=1, shift left each cycle; bit index counts PAT_W-1..0. On the last bit, decrement reps. If reps remain and gap>0, go to GAP. If reps remain and gap==0, reload PATTERN and stay in SEND (back-to-back, no bubble). If no reps remain, go to IDLE and pulse done.
  - GAP: out=0, out_valid=0, busy=1 for exactly gap cycles, then reload PATTERN and go to SEND.
- start while busy: ignored; counts are not recaptured.
- abort in SEND/GAP: next cycle state=IDLE, out=0, out_valid=0, busy=0, no done pulse.
- abort and start in the same IDLE cycle: abort wins; stay in IDLE.
- Reset mid-transmission: immediate return to reset values. No done pulse; no resume after reset release.
- When out_valid=0, out is forced to 0.
- Counters are unsigned and saturate-free. rep_cnt max = 2^REP_W-1 repetitions.

Optional Feature:
- Macro SEQ_GEN_ERR_INJECT_EN.
- When defined: adds input port inj_err (1 bit), captured with start. If captured high, the last bit of the first repetition only is inverted (1011 → 1010). The detector must then miss that repetition.
- When undefined: the port is absent, and transmission is always exactly PATTERN.

Decomposition:
- Shared package seq_pkg:
  - state typedef: IDLE=2'b00, SEND=2'b01, GAP=2'b10.
  - default pattern constant SEQ_PAT_1011=4'b1011.
  - width constants shared with the detector.
- One sub-module, seq_piso: PAT_W parallel-in serial-out shifter with load, shift and bit-index terminal flag.
- FSM and counters stay in the top-level module.

Test Plan:
- rep_cnt=1, gap=0, start at cycle 0 → out_valid cycles 1-4, out=1,0,1,1; done at cycle 5; busy cycles 1-4.
- rep_cnt=3, gap=0 → 12 contiguous bits 101110111011 in cycles 1-12, done at cycle 13. A connected detector asserts out 3 times.
- rep_cnt=2, gap=2 → bits in cycles 1-4, out_valid=0 in cycles 5-6, bits in cycles 7-10, done at cycle 11.
- rep_cnt=2, abort at cycle 2 → cycle 3: out_valid=0, busy=0, state IDLE; done never pulses. A start at cycle 3 is re-accepted.
- rep_cnt=0 start → done at cycle 1; out_valid never asserts. A start during busy (cycle 2 of a run) does not alter the bit sequence.
- rst low at cycle 3 of a run → outputs zero asynchronously; after release, stays IDLE until a new start.
- With SEQ_GEN_ERR_INJECT_EN and inj_err=1, rep_cnt=2 → bits 1010 1011; a connected detector fires once.
